// File: rtl/arcade_input_conditioner_if.sv
// Player-input bundle for arcade_input_conditioner: PS/2 key events, joysticks,
// orientation and vblank in; active-low input registers and coin status out.
interface arcade_input_conditioner_if;
  logic [10:0] ps2_key;
  logic [15:0] joy0;
  logic [15:0] joy1;
  logic        rotate;
  logic        vblank;
  logic [7:0]  in0_reg;
  logic [7:0]  in1_reg;
  logic        coin_busy;

  modport master (
    output ps2_key, joy0, joy1, rotate, vblank,
    input  in0_reg, in1_reg, coin_busy
  );

  modport slave (
    input  ps2_key, joy0, joy1, rotate, vblank,
    output in0_reg, in1_reg, coin_busy
  );
endinterface

// File: rtl/arcade_input_conditioner.sv
// Keyboard/joystick conditioner producing active-low arcade input registers and
// vblank-timed coin pulses. Define COIN_ON_START_EN to let start buttons insert coin1.
module arcade_input_conditioner #(
  parameter int unsigned COIN_FRAMES = 4,
  parameter int unsigned GAP_FRAMES  = 4
) (
  input  logic CLK,
  input  logic RESET,
  arcade_input_conditioner_if.slave bus
);

  localparam int unsigned KI_UP     = 0;
  localparam int unsigned KI_DOWN   = 1;
  localparam int unsigned KI_LEFT   = 2;
  localparam int unsigned KI_RIGHT  = 3;
  localparam int unsigned KI_UP2    = 4;
  localparam int unsigned KI_DOWN2  = 5;
  localparam int unsigned KI_LEFT2  = 6;
  localparam int unsigned KI_RIGHT2 = 7;
  localparam int unsigned KI_FIRE   = 8;
  localparam int unsigned KI_FIRE2  = 9;
  localparam int unsigned KI_START1 = 10;
  localparam int unsigned KI_START2 = 11;
  localparam int unsigned KI_COIN1  = 12;
  localparam int unsigned KI_COIN2  = 13;
  localparam int unsigned KI_TEST   = 14;

  localparam logic [3:0] LP_COIN = 4'(COIN_FRAMES);
  localparam logic [3:0] LP_GAP  = 4'(GAP_FRAMES);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PULSE,
    ST_GAP
  } state_t;

  logic        r_strobe;
  logic [14:0] r_keys;
  logic [4:0]  r_in0_low;
  logic [7:0]  r_in1;
  logic        r_vb_prev;
  logic        r_raw1_prev;
  logic        r_raw2_prev;
  state_t      r_state;
  logic [3:0]  r_cnt;
  logic        r_pend1;
  logic        r_pend2;
  logic        r_coin1;
  logic        r_coin2;
  logic        r_busy;

  logic w_key_evt;
  logic w_pressed;
  logic w_up, w_down, w_left, w_right;
  logic w_up2, w_down2, w_left2, w_right2;
  logic w_fire, w_fire2, w_start1, w_start2;
  logic w_raw_coin1, w_raw_coin2;
  logic w_req1, w_req2;
  logic w_vb_edge;
  logic w_unused;

  assign w_key_evt = bus.ps2_key[10] ^ r_strobe;
  assign w_pressed = bus.ps2_key[9];

  // One latch per function; aliased keys (e.g. both fire codes) share it.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_strobe <= 1'b0;
      r_keys   <= '0;
    end else begin
      r_strobe <= bus.ps2_key[10];
      if (w_key_evt) begin
        case (bus.ps2_key[8:0])
          9'h075, 9'h175: r_keys[KI_UP]     <= w_pressed;
          9'h072, 9'h172: r_keys[KI_DOWN]   <= w_pressed;
          9'h06B, 9'h16B: r_keys[KI_LEFT]   <= w_pressed;
          9'h074, 9'h174: r_keys[KI_RIGHT]  <= w_pressed;
          9'h029, 9'h014: r_keys[KI_FIRE]   <= w_pressed;
          9'h005, 9'h016: r_keys[KI_START1] <= w_pressed;
          9'h006, 9'h01E: r_keys[KI_START2] <= w_pressed;
          9'h02E:         r_keys[KI_COIN1]  <= w_pressed;
          9'h036:         r_keys[KI_COIN2]  <= w_pressed;
          9'h02D:         r_keys[KI_UP2]    <= w_pressed;
          9'h02B:         r_keys[KI_DOWN2]  <= w_pressed;
          9'h023:         r_keys[KI_LEFT2]  <= w_pressed;
          9'h034:         r_keys[KI_RIGHT2] <= w_pressed;
          9'h01C:         r_keys[KI_FIRE2]  <= w_pressed;
          9'h02C:         r_keys[KI_TEST]   <= w_pressed;
          default: ;
        endcase
      end
    end
  end

  // Horizontal cabinets turn the stick a quarter turn: left->up, right->down.
  assign w_up     = bus.rotate ? (r_keys[KI_LEFT]   | bus.joy0[1]) : (r_keys[KI_UP]     | bus.joy0[3]);
  assign w_down   = bus.rotate ? (r_keys[KI_RIGHT]  | bus.joy0[0]) : (r_keys[KI_DOWN]   | bus.joy0[2]);
  assign w_left   = bus.rotate ? (r_keys[KI_DOWN]   | bus.joy0[2]) : (r_keys[KI_LEFT]   | bus.joy0[1]);
  assign w_right  = bus.rotate ? (r_keys[KI_UP]     | bus.joy0[3]) : (r_keys[KI_RIGHT]  | bus.joy0[0]);
  assign w_up2    = bus.rotate ? (r_keys[KI_LEFT2]  | bus.joy1[1]) : (r_keys[KI_UP2]    | bus.joy1[3]);
  assign w_down2  = bus.rotate ? (r_keys[KI_RIGHT2] | bus.joy1[0]) : (r_keys[KI_DOWN2]  | bus.joy1[2]);
  assign w_left2  = bus.rotate ? (r_keys[KI_DOWN2]  | bus.joy1[2]) : (r_keys[KI_LEFT2]  | bus.joy1[1]);
  assign w_right2 = bus.rotate ? (r_keys[KI_UP2]    | bus.joy1[3]) : (r_keys[KI_RIGHT2] | bus.joy1[0]);

  assign w_fire   = r_keys[KI_FIRE]   | bus.joy0[4];
  assign w_fire2  = r_keys[KI_FIRE2]  | bus.joy1[4];
  assign w_start1 = r_keys[KI_START1] | bus.joy0[5] | bus.joy1[5];
  assign w_start2 = r_keys[KI_START2] | bus.joy0[6] | bus.joy1[6];

`ifdef COIN_ON_START_EN
  assign w_raw_coin1 = r_keys[KI_COIN1] | w_start1 | w_start2;
`else
  assign w_raw_coin1 = r_keys[KI_COIN1];
`endif
  assign w_raw_coin2 = r_keys[KI_COIN2];

  assign w_unused = ^{bus.joy0[15:7], bus.joy1[15:7]};

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_in0_low <= '1;
      r_in1     <= '1;
    end else begin
      r_in0_low <= ~{r_keys[KI_TEST], w_down, w_right, w_left, w_up};
      r_in1     <= ~{w_fire2, w_start2, w_start1, w_fire, w_down2, w_right2, w_left2, w_up2};
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_vb_prev   <= 1'b0;
      r_raw1_prev <= 1'b0;
      r_raw2_prev <= 1'b0;
    end else begin
      r_vb_prev   <= bus.vblank;
      r_raw1_prev <= w_raw_coin1;
      r_raw2_prev <= w_raw_coin2;
    end
  end

  assign w_req1    = w_raw_coin1 & ~r_raw1_prev;
  assign w_req2    = w_raw_coin2 & ~r_raw2_prev;
  assign w_vb_edge = bus.vblank & ~r_vb_prev;

  // Slot 1 has priority; a same-slot request on the IDLE->PULSE cycle is absorbed.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_pend1 <= 1'b0;
      r_pend2 <= 1'b0;
      r_coin1 <= 1'b0;
      r_coin2 <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_req1 || r_pend1) begin
            r_state <= ST_PULSE;
            r_cnt   <= LP_COIN;
            r_coin1 <= 1'b1;
            r_busy  <= 1'b1;
            r_pend1 <= 1'b0;
            r_pend2 <= r_pend2 | w_req2;
          end else if (w_req2 || r_pend2) begin
            r_state <= ST_PULSE;
            r_cnt   <= LP_COIN;
            r_coin2 <= 1'b1;
            r_busy  <= 1'b1;
            r_pend2 <= 1'b0;
          end
        end
        ST_PULSE: begin
          r_pend1 <= r_pend1 | w_req1;
          r_pend2 <= r_pend2 | w_req2;
          if (w_vb_edge) begin
            if (r_cnt <= 4'd1) begin
              r_state <= ST_GAP;
              r_cnt   <= LP_GAP;
              r_coin1 <= 1'b0;
              r_coin2 <= 1'b0;
            end else begin
              r_cnt <= r_cnt - 4'd1;
            end
          end
        end
        ST_GAP: begin
          r_pend1 <= r_pend1 | w_req1;
          r_pend2 <= r_pend2 | w_req2;
          if (w_vb_edge) begin
            if (r_cnt <= 4'd1) begin
              r_state <= ST_IDLE;
              r_cnt   <= '0;
              r_busy  <= 1'b0;
            end else begin
              r_cnt <= r_cnt - 4'd1;
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_cnt   <= '0;
          r_coin1 <= 1'b0;
          r_coin2 <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in0_reg   = {~r_coin2, 1'b1, ~r_coin1, r_in0_low};
  assign bus.in1_reg   = r_in1;
  assign bus.coin_busy = r_busy;

endmodule

// File: tb/tb_arcade_input_conditioner.sv
// Self-checking bench for arcade_input_conditioner: randomized key/joystick
// traffic against a key-state model, and coin sequences against an edge-count schedule.
module tb_arcade_input_conditioner;

  localparam int C = 4;
  localparam int G = 4;

  logic CLK;
  logic RESET;
  arcade_input_conditioner_if bus();

  arcade_input_conditioner #(.COIN_FRAMES(C), .GAP_FRAMES(G)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  logic        r_tog = 1'b0;
  logic [14:0] m_key = '0;

`ifdef COIN_ON_START_EN
  localparam int START_COINS = 1;
`else
  localparam int START_COINS = 0;
`endif

  // Function index of a scan code: 0-3 P1 u/d/l/r, 4-7 P2 u/d/l/r, 8 fire,
  // 9 fire2, 10 start1, 11 start2, 12 coin1, 13 coin2, 14 test.
  function automatic int key_index(input logic [8:0] code);
    case (code)
      9'h075, 9'h175: return 0;
      9'h072, 9'h172: return 1;
      9'h06B, 9'h16B: return 2;
      9'h074, 9'h174: return 3;
      9'h02D: return 4;
      9'h02B: return 5;
      9'h023: return 6;
      9'h034: return 7;
      9'h029, 9'h014: return 8;
      9'h01C: return 9;
      9'h005, 9'h016: return 10;
      9'h006, 9'h01E: return 11;
      9'h02E: return 12;
      9'h036: return 13;
      9'h02C: return 14;
      default: return -1;
    endcase
  endfunction

  // Returns {right,left,down,up} as seen by the game after optional rotation.
  function automatic logic [3:0] dirs(input logic [3:0] keys, input logic [15:0] joy, input logic rot);
    logic [3:0] phys;
    logic [3:0] d;
    logic [7:0] rot_src;
    rot_src = {2'd0, 2'd1, 2'd3, 2'd2};
    for (int i = 0; i < 4; i++) phys[i] = keys[i] | joy[3 - i];
    for (int i = 0; i < 4; i++) d[i] = rot ? phys[rot_src[2*i +: 2]] : phys[i];
    return d;
  endfunction

  function automatic logic [4:0] exp_in0_lo();
    logic [3:0] d;
    d = dirs(m_key[3:0], bus.joy0, bus.rotate);
    return ~{m_key[14], d[1], d[3], d[2], d[0]};
  endfunction

  function automatic logic [7:0] exp_in1();
    logic [3:0] d;
    d = dirs(m_key[7:4], bus.joy1, bus.rotate);
    return ~{m_key[9] | bus.joy1[4],
             m_key[11] | bus.joy0[6] | bus.joy1[6],
             m_key[10] | bus.joy0[5] | bus.joy1[5],
             m_key[8] | bus.joy0[4],
             d[1], d[3], d[2], d[0]};
  endfunction

  // Coin schedule after k vblank edges for n queued slots: {busy, coin2, coin1}.
  function automatic logic [2:0] coin_model(input int k, input int n, input int s0, input int s1, input int s2);
    int per;
    int idx;
    int slot;
    logic [2:0] r;
    per  = C + G;
    idx  = k / per;
    slot = (idx == 0) ? s0 : (idx == 1) ? s1 : s2;
    r    = '0;
    if (k < n * per) r[2] = 1'b1;
    if (idx < n && (k % per) < C) begin
      if (slot == 1) r[0] = 1'b1;
      else           r[1] = 1'b1;
    end
    return r;
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic send_key(input logic [8:0] code, input logic pressed);
    int idx;
    r_tog = ~r_tog;
    bus.ps2_key = {r_tog, pressed, code};
    idx = key_index(code);
    if (idx >= 0) m_key[idx] = pressed;
    tick(1);
  endtask

  task automatic vb_edge();
    bus.vblank = 1'b1;
    tick(1);
    bus.vblank = 1'b0;
    tick(int'($urandom_range(1, 3)));
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    bus.joy0 = 16'h007F;
    bus.joy1 = 16'h007F;
    bus.ps2_key = {1'b1, 1'b1, 9'h02E};
    bus.vblank = 1'b1;
    tick(2);
    bus.vblank = 1'b0;
    tick(2);
    checks++; if (bus.in0_reg !== 8'hFF) begin errors++; $display("FAIL reset_in0 got %h want ff", bus.in0_reg); end
    checks++; if (bus.in1_reg !== 8'hFF) begin errors++; $display("FAIL reset_in1 got %h want ff", bus.in1_reg); end
    checks++; if (bus.coin_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bus.coin_busy); end
    bus.joy0 = '0;
    bus.joy1 = '0;
    bus.ps2_key = '0;
    r_tog = 1'b0;
    m_key = '0;
    tick(1);
    RESET = 1'b0;
    tick(3);
    checks++; if (bus.in0_reg !== 8'hFF) begin errors++; $display("FAIL post_reset_in0 got %h want ff", bus.in0_reg); end
    checks++; if (bus.in1_reg !== 8'hFF) begin errors++; $display("FAIL post_reset_in1 got %h want ff", bus.in1_reg); end
  endtask

  task automatic test_key_up();
    bus.rotate = 1'b0;
    send_key(9'h075, 1'b1);
    tick(1);
    checks++; if (bus.in0_reg !== 8'hFE) begin errors++; $display("FAIL key_up_press got %h want fe", bus.in0_reg); end
    send_key(9'h075, 1'b0);
    tick(1);
    checks++; if (bus.in0_reg !== 8'hFF) begin errors++; $display("FAIL key_up_release got %h want ff", bus.in0_reg); end
    send_key(9'h175, 1'b1);
    tick(1);
    checks++; if (bus.in0_reg !== 8'hFE) begin errors++; $display("FAIL key_up_ext got %h want fe", bus.in0_reg); end
    send_key(9'h175, 1'b0);
    tick(1);
  endtask

  task automatic test_rotate();
    bus.rotate = 1'b1;
    bus.joy0 = 16'h0002;
    tick(1);
    checks++; if (bus.in0_reg !== 8'hFE) begin errors++; $display("FAIL rotate_left_is_up got %h want fe", bus.in0_reg); end
    bus.joy0 = '0;
    bus.rotate = 1'b0;
    tick(1);
    checks++; if (bus.in0_reg !== 8'hFF) begin errors++; $display("FAIL rotate_clear got %h want ff", bus.in0_reg); end
  endtask

  task automatic test_random_dirs();
    logic [8:0] codes [14];
    logic [7:0] e0;
    logic [7:0] e1;
    codes = '{9'h075, 9'h172, 9'h06B, 9'h074, 9'h02D, 9'h02B, 9'h023,
              9'h034, 9'h029, 9'h014, 9'h01C, 9'h02C, 9'h0AA, 9'h175};
    for (int it = 0; it < 80; it++) begin
      case ($urandom_range(0, 3))
        0, 1: begin
          send_key(codes[$urandom_range(0, 13)], 1'($urandom_range(0, 1)));
          tick(1);
        end
        2: begin
          bus.joy0 = 16'($urandom) & 16'hFF9F;
          bus.joy1 = 16'($urandom) & 16'hFF9F;
          tick(1);
        end
        default: begin
          bus.rotate = 1'($urandom_range(0, 1));
          tick(1);
        end
      endcase
      e0 = {3'b111, exp_in0_lo()};
      e1 = exp_in1();
      checks++; if (bus.in0_reg !== e0) begin errors++; $display("FAIL rand_in0 it=%0d got %h want %h", it, bus.in0_reg, e0); end
      checks++; if (bus.in1_reg !== e1) begin errors++; $display("FAIL rand_in1 it=%0d got %h want %h", it, bus.in1_reg, e1); end
    end
    foreach (codes[i]) send_key(codes[i], 1'b0);
    bus.joy0 = '0;
    bus.joy1 = '0;
    bus.rotate = 1'b0;
    tick(1);
    checks++; if (bus.in0_reg !== 8'hFF || bus.in1_reg !== 8'hFF) begin
      errors++; $display("FAIL rand_cleanup got %h/%h want ff/ff", bus.in0_reg, bus.in1_reg);
    end
  endtask

  task automatic test_coin_single();
    logic [2:0] m;
    logic [7:0] e0;
    send_key(9'h02E, 1'b1);
    tick(1);
    for (int k = 0; k <= 12; k++) begin
      if (k > 0) vb_edge();
      m  = coin_model(k, 1, 1, 0, 0);
      e0 = {~m[1], 1'b1, ~m[0], exp_in0_lo()};
      checks++; if (bus.in0_reg !== e0) begin errors++; $display("FAIL coin1_in0 k=%0d got %h want %h", k, bus.in0_reg, e0); end
      checks++; if (bus.coin_busy !== m[2]) begin errors++; $display("FAIL coin1_busy k=%0d got %b want %b", k, bus.coin_busy, m[2]); end
    end
    send_key(9'h02E, 1'b0);
    tick(1);
    vb_edge();
    checks++; if (bus.in0_reg !== 8'hFF) begin errors++; $display("FAIL coin1_after got %h want ff", bus.in0_reg); end
  endtask

  task automatic test_coin_both();
    logic [2:0] m;
    logic [7:0] e0;
    send_key(9'h02E, 1'b1);
    send_key(9'h036, 1'b1);
    tick(1);
    for (int k = 0; k <= 18; k++) begin
      if (k > 0) vb_edge();
      m  = coin_model(k, 2, 1, 2, 0);
      e0 = {~m[1], 1'b1, ~m[0], exp_in0_lo()};
      checks++; if (bus.in0_reg !== e0) begin errors++; $display("FAIL both_in0 k=%0d got %h want %h", k, bus.in0_reg, e0); end
      checks++; if (bus.coin_busy !== m[2]) begin errors++; $display("FAIL both_busy k=%0d got %b want %b", k, bus.coin_busy, m[2]); end
    end
    send_key(9'h02E, 1'b0);
    send_key(9'h036, 1'b0);
    tick(1);
  endtask

  task automatic test_back_to_back();
    logic [2:0] m;
    logic [7:0] e0;
    send_key(9'h02E, 1'b1);
    send_key(9'h02E, 1'b0);
    tick(1);
    for (int k = 0; k <= 26; k++) begin
      if (k > 0) vb_edge();
      if (k == 1) begin
        // Requests during PULSE: coin2 and coin1 queue, the repeated coin1 is dropped.
        send_key(9'h036, 1'b1);
        send_key(9'h02E, 1'b1);
        send_key(9'h02E, 1'b0);
        send_key(9'h02E, 1'b1);
        tick(1);
      end
      m  = coin_model(k, 3, 1, 1, 2);
      e0 = {~m[1], 1'b1, ~m[0], exp_in0_lo()};
      checks++; if (bus.in0_reg !== e0) begin errors++; $display("FAIL b2b_in0 k=%0d got %h want %h", k, bus.in0_reg, e0); end
      checks++; if (bus.coin_busy !== m[2]) begin errors++; $display("FAIL b2b_busy k=%0d got %b want %b", k, bus.coin_busy, m[2]); end
    end
    send_key(9'h036, 1'b0);
    send_key(9'h02E, 1'b0);
    tick(1);
  endtask

  task automatic test_reset_mid_pulse();
    send_key(9'h02E, 1'b1);
    tick(1);
    vb_edge();
    vb_edge();
    checks++; if (bus.in0_reg !== 8'hDF) begin errors++; $display("FAIL midpulse_pre got %h want df", bus.in0_reg); end
    RESET = 1'b1;
    tick(1);
    checks++; if (bus.in0_reg !== 8'hFF) begin errors++; $display("FAIL midpulse_rst_in0 got %h want ff", bus.in0_reg); end
    checks++; if (bus.coin_busy !== 1'b0) begin errors++; $display("FAIL midpulse_rst_busy got %b want 0", bus.coin_busy); end
    bus.ps2_key = '0;
    r_tog = 1'b0;
    m_key = '0;
    vb_edge();
    RESET = 1'b0;
    tick(1);
    for (int k = 0; k < 8; k++) begin
      vb_edge();
      checks++; if (bus.in0_reg !== 8'hFF || bus.coin_busy !== 1'b0) begin
        errors++; $display("FAIL midpulse_resume k=%0d got %h/%b want ff/0", k, bus.in0_reg, bus.coin_busy);
      end
    end
  endtask

  task automatic test_start();
    logic [2:0] m;
    logic [7:0] e0;
    bus.joy1 = 16'h0040;
    tick(1);
    checks++; if (bus.in1_reg !== 8'hBF) begin errors++; $display("FAIL start_joy_in1 got %h want bf", bus.in1_reg); end
    for (int k = 0; k <= 9; k++) begin
      if (k > 0) vb_edge();
      m  = coin_model(k, START_COINS, 1, 0, 0);
      e0 = {~m[1], 1'b1, ~m[0], exp_in0_lo()};
      checks++; if (bus.in0_reg !== e0) begin errors++; $display("FAIL start_joy_in0 k=%0d got %h want %h", k, bus.in0_reg, e0); end
      checks++; if (bus.coin_busy !== m[2]) begin errors++; $display("FAIL start_joy_busy k=%0d got %b want %b", k, bus.coin_busy, m[2]); end
    end
    bus.joy1 = '0;
    tick(1);
    send_key(9'h005, 1'b1);
    tick(1);
    checks++; if (bus.in1_reg !== 8'hDF) begin errors++; $display("FAIL start_key_in1 got %h want df", bus.in1_reg); end
    for (int k = 0; k <= 9; k++) begin
      if (k > 0) vb_edge();
      m  = coin_model(k, START_COINS, 1, 0, 0);
      e0 = {~m[1], 1'b1, ~m[0], exp_in0_lo()};
      checks++; if (bus.in0_reg !== e0) begin errors++; $display("FAIL start_key_in0 k=%0d got %h want %h", k, bus.in0_reg, e0); end
    end
    send_key(9'h005, 1'b0);
    tick(1);
    checks++; if (bus.in1_reg !== 8'hFF) begin errors++; $display("FAIL start_key_release got %h want ff", bus.in1_reg); end
  endtask

  initial begin
    RESET = 1'b1;
    bus.ps2_key = '0;
    bus.joy0 = '0;
    bus.joy1 = '0;
    bus.rotate = 1'b0;
    bus.vblank = 1'b0;
    test_reset();
    test_key_up();
    test_rotate();
    test_random_dirs();
    test_coin_single();
    test_coin_both();
    test_back_to_back();
    test_reset_mid_pulse();
    test_start();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired after %0d checks", checks);
    $fatal(1);
  end

endmodule
